// File: rtl/porta_pkg.sv
// Shared types and constants for the PORTA serial transmitter.
package porta_pkg;

  // Transmitter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Start + 8 data + stop.
  localparam int FRAME_BITS = 10;

  // STATUS byte bit positions.
  localparam int STS_OVERRUN = 7;
  localparam int STS_FULL    = 6;
  localparam int STS_EMPTY   = 5;
  localparam int STS_BUSY    = 4;
  localparam int STS_ZERO    = 3;

  // The status count field is only 3 bits wide, so deep FIFOs report 7.
  function automatic logic [2:0] sat_count(input logic [4:0] c);
    return (c > 5'd7) ? 3'd7 : c[2:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. A push into a full FIFO is still taken
// when a pop frees the head slot on the same edge.
module sync_fifo
  import porta_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  output logic [DATA_WIDTH-1:0]        head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         accept_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pop_ok, push_ok;

  assign full_o   = (cnt_q == FULL_CNT);
  assign empty_o  = (cnt_q == '0);
  assign pop_ok   = pop_i && !empty_o;
  assign push_ok  = push_i && (!full_o || pop_ok);
  assign accept_o = push_ok;
  assign head_o   = mem_q[rd_q];
  assign count_o  = cnt_q;

  // Pointer and occupancy next-state; pointers wrap because DEPTH is a power of two.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (pop_ok)  rd_d = rd_q + AW'(1);
    if (push_ok) wr_d = wr_q + AW'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + CW'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - CW'(1);
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage; when full with a pop, wr_q == rd_q and the head is overwritten
  // only after it has been read out on this edge.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/porta_tx.sv
// PORTA serial transmitter: queues core writes and sends them as 8N1 frames,
// reporting FIFO/line status back through the PORTA input path.
module porta_tx
  import porta_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic                  TX,
  output logic [7:0]            STATUS
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  tx_state_e             state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  ovr_q, ovr_d;
  logic [7:0]            status_q, status_d;

  logic                  pop, accept, full, empty;
  logic [DATA_WIDTH-1:0] head;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  baud_last;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (nRST),
    .push_i   (WR_EN),
    .pop_i    (pop),
    .data_i   (DATA_IN),
    .head_o   (head),
    .count_o  (cnt),
    .full_o   (full),
    .empty_o  (empty),
    .accept_o (accept)
  );

  assign baud_last = (baud_q == BAUD_LAST);
  // FIFO occupancy as it will be after this edge (pop only happens when non-empty).
  assign cnt_nxt   = cnt + CW'(accept) - CW'(pop);

  // Frame sequencer: next state, counters, shift register and FIFO pop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) state_d = ST_STOP;
          else                   bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next frame so queued bytes go out gap-free.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level, overrun flag and status byte, all taken from next-state values
  // so they line up with the edge that causes them.
  always_comb begin
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    ovr_d                 = ovr_q | (WR_EN & ~accept);
    status_d              = '0;
    status_d[STS_OVERRUN] = ovr_d;
    status_d[STS_FULL]    = (cnt_nxt == FULL_CNT);
    status_d[STS_EMPTY]   = (cnt_nxt == '0);
    status_d[STS_BUSY]    = (state_d != ST_IDLE);
    status_d[STS_ZERO]    = 1'b0;
    status_d[2:0]         = sat_count(5'(cnt_nxt));
  end

  // State registers; reset aborts any frame in flight and parks the line high.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ovr_q    <= 1'b0;
      status_q <= 8'h20;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovr_q    <= ovr_d;
      status_q <= status_d;
    end
  end

  assign TX     = tx_q;
  assign STATUS = status_q;

endmodule

// File: tb/tb_porta_tx.sv
// Randomized bench for porta_tx: a frame-level reference model predicts the
// line level and status every cycle, and a UART-style monitor decodes TX frames
// and checks them against the queue of accepted bytes.
module tb_porta_tx;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       WR_EN = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic       TX;
  logic [7:0] STATUS;

  porta_tx #(.DATA_WIDTH(8), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .nRST(nRST), .WR_EN(WR_EN), .DATA_IN(DATA_IN), .TX(TX), .STATUS(STATUS)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queued bytes, current frame, sticky overrun.
  logic [7:0] mq[$];
  logic [7:0] sb_q[$];
  bit         m_busy = 0;
  bit         m_ovr  = 0;
  int         m_start = 0;
  logic [7:0] m_byte = 8'h00;
  int         cyc = 0;
  bit         mon_abort = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int b;
    logic [7:0] v;
    if (!m_busy) return 1'b1;
    b = (cyc - m_start) / CPB;
    v = m_byte;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return v[b-1];
  endfunction

  function automatic logic [7:0] exp_status();
    int n;
    n = mq.size();
    return {m_ovr, n == DEPTH, n == 0, m_busy, 1'b0, 3'(n > 7 ? 7 : n)};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_busy = 0;
    m_ovr  = 0;
  endtask

  // One clock edge of the model: frame end / pop first, then the write.
  task automatic model_step(input bit wr, input logic [7:0] d);
    bit full_pre, popped;
    cyc++;
    if (!nRST) begin
      model_reset();
      return;
    end
    full_pre = (mq.size() == DEPTH);
    popped   = 0;
    if (!m_busy || cyc == m_start + FRAME) begin
      if (mq.size() > 0) begin
        m_byte  = mq.pop_front();
        m_busy  = 1;
        m_start = cyc;
        popped  = 1;
      end else begin
        m_busy = 0;
      end
    end
    if (wr) begin
      if (!full_pre || popped) begin
        mq.push_back(d);
        sb_q.push_back(d);
      end else begin
        m_ovr = 1;
      end
    end
  endtask

  // Drive at negedge, step model at posedge, check at the following negedge.
  task automatic tick(input bit wr, input logic [7:0] d);
    WR_EN   = wr;
    DATA_IN = d;
    @(posedge CLK);
    model_step(wr, d);
    @(negedge CLK);
    chk("tx_level", TX, exp_tx());
    chk("status", STATUS, exp_status());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom));
  endtask

  // Frame decoder: samples each bit mid-way and scores completed bytes.
  initial begin : monitor
    bit         act;
    int         ph;
    logic [9:0] fr;
    logic [7:0] exp;
    act = 0; ph = 0; fr = '0;
    forever begin
      @(negedge CLK);
      if (mon_abort) begin
        act = 0;
        mon_abort = 0;
      end else if (!act) begin
        if (nRST && TX === 1'b0) begin act = 1; ph = 0; end
      end else begin
        ph++;
      end
      if (act && (ph % CPB) == 2) begin
        fr[ph / CPB] = TX;
        if (ph / CPB == 9) begin
          act = 0;
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_frame: got byte %0h expected no frame at t=%0t", fr[8:1], $time);
          end else begin
            exp = sb_q.pop_front();
            chk("rx_byte", fr[8:1], exp);
            chk("rx_stop", fr[9], 1'b1);
          end
        end
      end
    end
  end

  initial begin : stim
    int guard;
    // Reset held with writes toggling: nothing may be queued.
    nRST = 1'b0;
    for (int i = 0; i < 6; i++) tick(i[0], 8'hE0 + 8'(i));
    chk("rst_status", STATUS, 8'h20);
    chk("rst_tx", TX, 1'b1);
    nRST = 1'b1;
    idle(3);
    chk("post_rst_status", STATUS, 8'h20);

    // Single byte.
    tick(1'b1, 8'hA5);
    idle(45);
    chk("a5_done_status", STATUS, 8'h20);

    // Back-to-back frames.
    tick(1'b1, 8'h01);
    tick(1'b1, 8'h80);
    idle(90);

    // Overrun: one frame in flight, five more writes, the last is dropped.
    tick(1'b1, 8'h33);
    idle(2);
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h10 + 8'(i));
    chk("ovr_status", STATUS, 8'hD4);
    idle(5 * FRAME + 10);
    chk("ovr_drain_status", STATUS, 8'hA0);

    // Clear the sticky overrun.
    nRST = 1'b0;
    sb_q.delete();
    mon_abort = 1;
    tick(1'b0, 8'h00);
    nRST = 1'b1;
    tick(1'b0, 8'h00);
    chk("clr_status", STATUS, 8'h20);

    // Full FIFO with a write on the stop-final edge.
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h40 + 8'(i));
    guard = 0;
    while (!(m_busy && cyc + 1 == m_start + FRAME) && guard < 100) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL fullpop_wait: got timeout expected stop-final edge");
    end
    tick(1'b1, 8'h55);
    chk("fullpop_status", STATUS, 8'h54);
    idle(5 * FRAME + 10);
    chk("fullpop_drain_status", STATUS, 8'h20);

    // Random traffic, then drain.
    for (int i = 0; i < 400; i++) tick($urandom_range(0, 24) == 0, 8'($urandom));
    for (int i = 0; i < 8; i++) tick(1'b1, 8'($urandom));
    guard = 0;
    while ((m_busy || mq.size() > 0) && guard < 400) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    idle(2);

    // Mid-frame reset during data bit 3.
    tick(1'b1, 8'hC3);
    tick(1'b1, 8'h3C);
    guard = 0;
    while (!(m_busy && (cyc - m_start) / CPB == 4) && guard < 60) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    if (guard >= 60) begin
      n_cmp++; n_err++;
      $display("FAIL midrst_wait: got timeout expected data bit 3");
    end
    #1 nRST = 1'b0;
    model_reset();
    sb_q.delete();
    mon_abort = 1;
    #1;
    chk("midrst_tx", TX, 1'b1);
    chk("midrst_status", STATUS, 8'h20);
    #1 nRST = 1'b1;
    idle(60);
    chk("midrst_after_status", STATUS, 8'h20);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
